// File: rtl/mul_seq_array.sv
`default_nettype none
// ============================================================================
// Module   : mul_seq_array
// Brief    : Sequential unsigned mantissa multiplier. Multiplies a by one
//            DIGIT-bit slice of b per cycle and accumulates into a 2*WIDTH
//            accumulator. Valid/ready handshakes on input and output.
//            Optional macro MUL_STICKY_EN adds a sticky output equal to the
//            OR of acc[WIDTH-3:0], used by the rounding stage.
// Revision : 1.0 - initial release
// ============================================================================
module mul_seq_array #(
  parameter int WIDTH = 24,
  parameter int DIGIT = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] c,
  output logic               busy
`ifdef MUL_STICKY_EN
  ,
  output logic               sticky
`endif
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = $clog2(N) + 1;
  localparam int PW = 2 * WIDTH;
  localparam logic [CW-1:0] C_LAST = CW'(N - 1);
  localparam logic [CW-1:0] C_ONE  = CW'(1);

  // b must split into whole digits, otherwise the iteration count is wrong
  generate
    if ((DIGIT < 1) || (WIDTH % DIGIT != 0)) begin : g_bad_digit
      $error("mul_seq_array: WIDTH must be a multiple of DIGIT");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_DONE = 2'b10
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [WIDTH-1:0]  r_a;
  logic [WIDTH-1:0]  r_b;
  logic [PW-1:0]     r_acc;
  logic [CW-1:0]     r_cnt;
  logic [31:0]       w_shamt;
  logic [DIGIT-1:0]  w_digit;
  logic [PW-1:0]     w_pp;
  logic [PW-1:0]     w_pp_sh;
  logic              w_accept;
  logic              w_last;

  // Bit offset of the current digit; also the weight of its partial product.
  assign w_shamt = 32'(r_cnt) * 32'(DIGIT);
  assign w_digit = r_b[w_shamt +: DIGIT];
  assign w_pp    = {{WIDTH{1'b0}}, r_a} * {{(PW-DIGIT){1'b0}}, w_digit};
  assign w_pp_sh = w_pp << w_shamt;
  assign w_last  = (r_cnt == C_LAST);

  // A finished result can be handed off and a new operand taken on one edge.
  assign in_ready  = (r_state == S_IDLE) || ((r_state == S_DONE) && out_ready);
  assign w_accept  = in_valid && in_ready;
  assign out_valid = (r_state == S_DONE);
  assign busy      = (r_state == S_RUN);
  assign c         = r_acc;

`ifdef MUL_STICKY_EN
  assign sticky = |r_acc[WIDTH-3:0];
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic; the unused encoding falls back to IDLE
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (w_accept) w_state_nxt = S_RUN;
      S_RUN:  if (w_last)   w_state_nxt = S_DONE;
      S_DONE: begin
        if (w_accept)       w_state_nxt = S_RUN;
        else if (out_ready) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Operand capture and digit-serial accumulation (fixed N iterations)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a   <= '0;
      r_b   <= '0;
      r_acc <= '0;
      r_cnt <= '0;
    end else if (w_accept) begin
      r_a   <= a;
      r_b   <= b;
      r_acc <= '0;
      r_cnt <= '0;
    end else if (r_state == S_RUN) begin
      r_acc <= r_acc + w_pp_sh;
      r_cnt <= r_cnt + C_ONE;
    end
  end

endmodule
`default_nettype wire
